dcache_ctrl: RTL

- Parametrised write-back, write-allocate, N-way set-associative data cache with true-LRU replacement.
- Sits between the EX_MEM pipeline register (MEM stage) and a line-wide backing Data_Memory.
- Holds the pipeline with a stall output on a miss and refills through a req/ack handshake that tolerates any memory latency.
- Tag, valid, dirty, LRU and data arrays are internal registers.

---
 rtl/dcache_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - write-back, write-allocate, N-way set-associative data cache with true-LRU
// Hits are served combinationally; misses stall the MEM stage while the line is written back and refilled.
module dcache_ctrl #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  localparam int OFF = $clog2(LINE_W / 8);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - OFF - IDX;
  localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [AW-1:0] OLDEST = AW'(WAYS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;
  typedef logic [WAYS-1:0][AW-1:0] age_row_t;

  state_t            state_q, state_d;
  logic [TAG-1:0]    tag_q   [SETS][WAYS];
  logic [TAG-1:0]    tag_d   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_d  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAYS-1:0]   dirty_d [SETS];
  age_row_t          age_q   [SETS];
  age_row_t          age_d   [SETS];
  logic [AW-1:0]     victim_q, victim_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic [TAG-1:0]    req_tag, fill_tag;
  logic [IDX-1:0]    req_idx, fill_idx;
  logic [OFF-3:0]    req_word;
  logic              hit;
  logic [AW-1:0]     hit_way, victim;
  logic              unused_addr_lsb;

  assign req_tag         = cpu_addr_i[31:OFF+IDX];
  assign req_idx         = cpu_addr_i[OFF+IDX-1:OFF];
  assign req_word        = cpu_addr_i[OFF-1:2];
  assign fill_tag        = mem_addr_q[31:OFF+IDX];
  assign fill_idx        = mem_addr_q[OFF+IDX-1:OFF];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

  // A refill treats the incoming way as oldest, so ages become a permutation even from all-zero reset.
  function automatic age_row_t touch(input age_row_t row, input logic [AW-1:0] way,
                                     input logic [AW-1:0] ref_age);
    age_row_t r;
    r = row;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == way) r[AW'(w)] = '0;
      else if (row[AW'(w)] < ref_age) r[AW'(w)] = row[AW'(w)] + AW'(1);
    end
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][AW'(w)] && tag_q[req_idx][AW'(w)] == req_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (age_q[req_idx][AW'(w)] == OLDEST) victim = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[req_idx][AW'(w)]) victim = AW'(w);
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    data_d     = data_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    age_d      = age_q;
    victim_d   = victim_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cpu_stall_o = (state_q != S_IDLE) || (cpu_req_i && !hit);
    cpu_data_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i && hit) begin
          cpu_data_o     = data_q[req_idx][hit_way][{req_word, 5'b0} +: 32];
          age_d[req_idx] = touch(age_q[req_idx], hit_way, age_q[req_idx][hit_way]);
          if (cpu_we_i) begin
            data_d[req_idx][hit_way][{req_word, 5'b0} +: 32] = cpu_data_i;
            dirty_d[req_idx][hit_way] = 1'b1;
          end
        end else if (cpu_req_i) begin
          victim_d  = victim;
          mem_req_d = 1'b1;
          if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
            state_d    = S_WB;
            mem_we_d   = 1'b1;
            mem_addr_d = {tag_q[req_idx][victim], req_idx, {OFF{1'b0}}};
            mem_data_d = data_q[req_idx][victim];
          end else begin
            state_d    = S_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, req_idx, {OFF{1'b0}}};
          end
        end
      end
      S_WB: begin
        if (mem_ack_i) begin
          state_d    = S_FILL;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx, {OFF{1'b0}}};
        end
      end
      S_FILL: begin
        // The first FILL cycle after a writeback keeps the request low to separate the two transactions.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack_i) begin
          data_d[fill_idx][victim_q]  = mem_data_i;
          tag_d[fill_idx][victim_q]   = fill_tag;
          valid_d[fill_idx][victim_q] = 1'b1;
          dirty_d[fill_idx][victim_q] = 1'b0;
          age_d[fill_idx] = touch(age_q[fill_idx], victim_q, OLDEST);
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      victim_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        age_q[s]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      age_q      <= age_d;
    end
  end

  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule
